can_bit_timing: RTL
===================

Name: can_bit_timing

Overview:
- Bit-timing stage upstream of the frame decoder. Turns the raw asynchronous CAN RX line into a sampled bit stream.
- Outputs a one-cycle sample-point strobe SP with the sampled bit RX_S, both consumed by the frame maker, error block and overload block.
- Does hard synchronization on start-of-frame and resynchronization limited by the synchronization jump width (SJW).
- Tracks bus-idle integration: 11 consecutive recessive bits.

Parameters:
- BRP, 4: system clocks per time quantum (tq); BRP >= 1.
- TSEG1, 13: tq in propagation + phase segment 1; TSEG1 >= TSEG2.
- TSEG2, 2: tq in phase segment 2; TSEG2 >= SJW.
- SJW, 1: synchronization jump width in tq; SJW >= 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- RX  in  1  raw bus line, asynchronous; 1 = recessive.
- SP  out  1  one-clock sample-point strobe.
- RX_S  out  1  sampled bit; updates on the same edge SP rises, held between strobes.
- BUS_IDLE  out  1  high after 11 consecutive recessive samples.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high. It clears all state on the next edge, including mid-bit.
- Reset values: SP=0, RX_S=1, BUS_IDLE=0, synchronizer flops=1, prescaler=0, state=SYNC, idle count=0, resync flag=0.
- Input path: 2-flop synchronizer produces rx_sync; rx_prev is rx_sync delayed one cycle. falling_edge = rx_prev & ~rx_sync. Pin-to-rx_sync latency is 2 clocks.
- Prescaler: counts 0..BRP-1; tq_tick when count==BRP-1.
- Segment FSM advances on tq_tick, through three states:
  - SYNC (1 tq) -> SEG1.
  - SEG1 (TSEG1 + ext tq) -> SEG2.
  - SEG2 (TSEG2 - shrink tq) -> SYNC.
  - ext and shrink are cleared at SYNC entry.
- Sample point: on the tq_tick that ends SEG1:
  - RX_S <= rx_sync and SP <= 1 for exactly one clock.
  - Nominal bit = (1+TSEG1+TSEG2)*BRP = 64 clocks; free-runs from reset.
- Hard sync (BUS_IDLE=1 and falling_edge):
  - Prescaler restarts at 1; FSM enters SYNC with tq position 0, so the edge cycle is the first clock of SYNC.
  - BUS_IDLE <= 0; resync flag cleared.
  - Next SP rises (1+TSEG1)*BRP = 56 clocks after the cycle falling_edge is seen.
  - Hard sync overrides any resync in the same cycle.
- Resync applies only when all of these hold: BUS_IDLE=0, falling_edge, last RX_S==1, resync flag==0, state != SYNC. Then:
  - Edge in SEG1 at tq index p (0-based) is late. Phase error e = p+1; ext = min(e, SJW).
  - Edge in SEG2 with r tq remaining, including the current one, is early.
    - If r <= SJW: the bit ends now. Behaves like a hard sync without clearing BUS_IDLE; the current clock starts SYNC.
    - Else: shrink = SJW.
  - Set resync flag; it clears at SYNC entry. At most one resync per bit.
- Edges ignored:
  - Edges while in SYNC: no adjustment.
  - Rising edges: never resynchronize.
- Idle counter, updated at each SP:
  - RX_S=1: counter++, saturating at 11. BUS_IDLE <= 1 when it reaches 11.
  - RX_S=0: counter=0, BUS_IDLE <= 0.
- Simultaneous events:
  - SEG1-end tq_tick coincident with a late edge: ext applies first and SP is postponed.
  - SEG2-end tq_tick coincident with an early edge: treated as an edge in the next bit's SYNC, so ignored.
- Widths: tq counter is clog2(TSEG1+SJW+1) bits; prescaler is clog2(BRP) bits, minimum 1.

Decomposition:
- Package can_timing_pkg:
  - Segment-state enum (SYNC, SEG1, SEG2).
  - IDLE_BITS=11.
  - Default timing constants.
  - Recessive/dominant bit constants.
- Sub-module can_rx_sync: 2-flop synchronizer plus falling-edge detector; outputs rx_sync and falling_edge.
- Prescaler, FSM, resync and idle logic stay in can_bit_timing.

Test Plan:
- Reset/integration: reset 3 cycles with RX=1 -> SP=0, RX_S=1, BUS_IDLE=0. SP period is then 64 clocks. BUS_IDLE rises on the 11th SP.
- Hard sync: after idle, drive RX=0 at pin cycle T -> falling_edge at T+2. SP at T+2+56 with RX_S=0, then BUS_IDLE=0. Next SP 64 clocks later.
- Late edge: RX 1->0 in SEG1 at tq index 0 -> SEG1 extended by 1 tq. SP delayed 4 clocks vs nominal; the following bit is nominal 64.
- Early edge, r<=SJW: RX 1->0 in the last SEG2 tq -> new SYNC starts that clock. Next SP 56 clocks after the edge.
- Rising edge and second edge in a bit: RX 0->1 mid-SEG1 -> no shift. Two 1->0 edges in one bit, separated by a 0->1 -> only the first adjusts timing.
- Mid-operation reset: assert reset during SEG1 -> SP=0 and BUS_IDLE=0 next clock. First SP lands 56 clocks after reset release.

Source files
------------

// File: rtl/can_timing_pkg.sv
// can_timing_pkg: segment states and timing constants shared by the CAN bit-timing stage.
package can_timing_pkg;
    typedef enum logic [1:0] {SYNC, SEG1, SEG2} seg_e;
    localparam int   IDLE_BITS = 11;
    localparam int   DEF_BRP   = 4;
    localparam int   DEF_TSEG1 = 13;
    localparam int   DEF_TSEG2 = 2;
    localparam int   DEF_SJW   = 1;
    localparam logic RECESSIVE = 1'b1;
    localparam logic DOMINANT  = 1'b0;
endpackage

// File: rtl/can_rx_sync.sv
// can_rx_sync: two-flop synchronizer for the raw CAN RX pin plus recessive-to-dominant edge detect.
module can_rx_sync
    import can_timing_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_rx,
    output logic o_rx_sync,
    output logic o_falling_edge
);
    logic r_meta, r_sync, r_prev;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_meta <= RECESSIVE;
            r_sync <= RECESSIVE;
            r_prev <= RECESSIVE;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end
    assign o_rx_sync      = r_sync;
    assign o_falling_edge = r_prev & ~r_sync;
endmodule

// File: rtl/can_bit_timing.sv
// can_bit_timing: tq prescaler, SYNC/SEG1/SEG2 bit FSM with hard sync and SJW-limited resync,
// sample-point strobe and 11-bit bus-idle integration.
module can_bit_timing
    import can_timing_pkg::*;
#(
    parameter int BRP   = DEF_BRP,
    parameter int TSEG1 = DEF_TSEG1,
    parameter int TSEG2 = DEF_TSEG2,
    parameter int SJW   = DEF_SJW
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_rx,
    output logic o_sp,
    output logic o_rx_s,
    output logic o_bus_idle
);
    localparam int PW = (BRP > 1) ? $clog2(BRP) : 1;
    localparam int TW = $clog2(TSEG1 + SJW + 1);
    localparam int CW = $clog2(IDLE_BITS + 1);

    logic          w_rx_sync, w_fall, w_tick, w_hard, w_resync, w_early;
    logic          w_seg1_end, w_seg2_end;
    logic [TW-1:0] w_p1, w_rem, w_ext, w_shrink;
    logic [PW-1:0] r_psc;
    logic [TW-1:0] r_tq, r_ext, r_shrink;
    logic [CW-1:0] r_idle;
    seg_e          r_state;
    logic          r_resync, r_sp, r_rx_s, r_bus_idle;

    can_rx_sync u_sync (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_rx          (i_rx),
        .o_rx_sync     (w_rx_sync),
        .o_falling_edge(w_fall)
    );

    assign w_tick   = r_psc == PW'(BRP - 1);
    assign w_hard   = r_bus_idle & w_fall;
    assign w_p1     = r_tq + 1'b1;
    assign w_rem    = TW'(TSEG2) - r_tq;
    // An edge on the tick that closes SEG2 belongs to the next bit's SYNC and is ignored.
    assign w_resync = !r_bus_idle && w_fall && r_rx_s && !r_resync && r_state != SYNC
                      && !(r_state == SEG2 && w_tick && r_tq == TW'(TSEG2 - 1));
    assign w_early  = w_resync && r_state == SEG2 && w_rem <= TW'(SJW);
    assign w_ext    = (w_resync && r_state == SEG1) ? ((w_p1 < TW'(SJW)) ? w_p1 : TW'(SJW)) : r_ext;
    assign w_shrink = (w_resync && r_state == SEG2) ? TW'(SJW) : r_shrink;
    assign w_seg1_end = r_state == SEG1 && r_tq == TW'(TSEG1) + w_ext - 1'b1;
    assign w_seg2_end = r_state == SEG2 && r_tq == TW'(TSEG2) - w_shrink - 1'b1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_psc      <= '0;
            r_state    <= SYNC;
            r_tq       <= '0;
            r_ext      <= '0;
            r_shrink   <= '0;
            r_resync   <= 1'b0;
            r_idle     <= '0;
            r_sp       <= 1'b0;
            r_rx_s     <= RECESSIVE;
            r_bus_idle <= 1'b0;
        end else if (w_hard || w_early) begin
            // The edge cycle itself is the first clock of SYNC.
            r_psc    <= (BRP == 1) ? '0 : PW'(1);
            r_state  <= (BRP == 1) ? SEG1 : SYNC;
            r_tq     <= '0;
            r_ext    <= '0;
            r_shrink <= '0;
            r_resync <= 1'b0;
            r_sp     <= 1'b0;
            if (w_hard) r_bus_idle <= 1'b0;
        end else begin
            r_psc    <= w_tick ? '0 : r_psc + 1'b1;
            r_ext    <= w_ext;
            r_shrink <= w_shrink;
            r_resync <= r_resync | w_resync;
            r_sp     <= w_tick && w_seg1_end;
            if (w_tick) begin
                r_tq <= r_tq + 1'b1;
                if (r_state == SYNC) begin
                    r_state <= SEG1;
                    r_tq    <= '0;
                end else if (w_seg1_end) begin
                    r_state    <= SEG2;
                    r_tq       <= '0;
                    r_rx_s     <= w_rx_sync;
                    r_idle     <= w_rx_sync ? ((r_idle == CW'(IDLE_BITS)) ? r_idle : r_idle + 1'b1) : '0;
                    r_bus_idle <= w_rx_sync && r_idle >= CW'(IDLE_BITS - 1);
                end else if (w_seg2_end) begin
                    r_state  <= SYNC;
                    r_tq     <= '0;
                    r_ext    <= '0;
                    r_shrink <= '0;
                    r_resync <= 1'b0;
                end
            end
        end
    end

    assign o_sp       = r_sp;
    assign o_rx_s     = r_rx_s;
    assign o_bus_idle = r_bus_idle;
endmodule
